// File: rtl/load_store_unit_if.sv
// Request/response handshake and data-memory port bundle for the load/store unit.
// The slave modport is the unit itself; the master modport is its environment (requester plus memory).
interface load_store_unit_if #(
    parameter int N_ADDR = 8,
    parameter int N_BIT  = 32
) ();
    logic              Req_valid;
    logic              Req_ready;
    logic              Req_store;
    logic [2:0]        Req_funct3;
    logic [31:0]       Req_addr;
    logic [N_BIT-1:0]  Req_wdata;
    logic              Resp_valid;
    logic [N_BIT-1:0]  Resp_rdata;
    logic [1:0]        Resp_err;
    logic [N_ADDR-1:0] Mem_Addr;
    logic [N_BIT-1:0]  Mem_Wr_data;
    logic              MemWrite;
    logic              MemRead;
    logic [N_BIT-1:0]  Mem_Rd_data;

    modport slave (
        input  Req_valid, Req_store, Req_funct3, Req_addr, Req_wdata, Mem_Rd_data,
        output Req_ready, Resp_valid, Resp_rdata, Resp_err,
               Mem_Addr, Mem_Wr_data, MemWrite, MemRead
    );

    modport master (
        output Req_valid, Req_store, Req_funct3, Req_addr, Req_wdata, Mem_Rd_data,
        input  Req_ready, Resp_valid, Resp_rdata, Resp_err,
               Mem_Addr, Mem_Wr_data, MemWrite, MemRead
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte-addressed RISC-V load/store front end for a word-addressed data memory.
// Sub-word stores use read-modify-write; loads are lane-extracted and sign/zero extended.
module load_store_unit #(
    parameter int N_ADDR = 8,
    parameter int N_BIT  = 32
) (
    input  logic Clk,
    input  logic Rst,
    load_store_unit_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD, CAP, MERGE, WR, RESP} state_t;

    state_t      state;
    logic [1:0]  lane_q;
    logic [2:0]  f3_q;
    logic        store_q;
    logic [15:0] wdata_q;
    logic [1:0]  err_q;
    logic [1:0]  req_err;
    logic        accept;

    function automatic logic [1:0] check_err(input logic store, input logic [2:0] f3,
                                             input logic [31:0] addr);
        logic illegal, range, misal;
        illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (store && f3[2]);
        range   = |(addr >> (N_ADDR + 2));
        misal   = ((f3[1:0] == 2'b01) && addr[0]) || ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        if (illegal)    check_err = 2'b11;
        else if (range) check_err = 2'b10;
        else if (misal) check_err = 2'b01;
        else            check_err = 2'b00;
    endfunction

    function automatic logic [N_BIT-1:0] format_load(input logic [2:0] f3, input logic [1:0] lane,
                                                     input logic [N_BIT-1:0] word);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = word[8*lane +: 8];
        h = word[16*lane[1] +: 16];
        case (f3)
            3'b000:  format_load = N_BIT'(b);
            3'b001:  format_load = N_BIT'(h);
            3'b100:  format_load = N_BIT'($unsigned(b));
            3'b101:  format_load = N_BIT'($unsigned(h));
            default: format_load = word;
        endcase
    endfunction

    // Only SB and SH reach the merge; funct3[0] selects half over byte.
    function automatic logic [N_BIT-1:0] merge_store(input logic half, input logic [1:0] lane,
                                                     input logic [N_BIT-1:0] old,
                                                     input logic [15:0] wd);
        merge_store = old;
        if (half) merge_store[16*lane[1] +: 16] = wd;
        else      merge_store[8*lane +: 8]      = wd[7:0];
    endfunction

    assign bus.Req_ready = (state == IDLE);
    assign accept        = bus.Req_valid && (state == IDLE);
    assign req_err       = check_err(bus.Req_store, bus.Req_funct3, bus.Req_addr);

    // Request capture: pure data, no reset needed.
    always_ff @(posedge Clk) begin
        if (accept) begin
            lane_q  <= bus.Req_addr[1:0];
            f3_q    <= bus.Req_funct3;
            store_q <= bus.Req_store;
            wdata_q <= bus.Req_wdata[15:0];
            err_q   <= req_err;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state           <= IDLE;
            bus.Resp_valid  <= 1'b0;
            bus.MemWrite    <= 1'b0;
            bus.MemRead     <= 1'b0;
            bus.Resp_rdata  <= '0;
            bus.Resp_err    <= 2'b00;
            bus.Mem_Addr    <= '0;
            bus.Mem_Wr_data <= '0;
        end else begin
            bus.Resp_valid <= 1'b0;
            bus.MemWrite   <= 1'b0;
            bus.MemRead    <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Req_valid) begin
                        if (req_err != 2'b00) begin
                            state <= RESP;
                        end else begin
                            bus.Mem_Addr <= bus.Req_addr[N_ADDR+1:2];
                            if (bus.Req_store && (bus.Req_funct3[1:0] == 2'b10)) begin
                                bus.Mem_Wr_data <= bus.Req_wdata;
                                bus.MemWrite    <= 1'b1;
                                state           <= WR;
                            end else begin
                                bus.MemRead <= 1'b1;
                                state       <= RD;
                            end
                        end
                    end
                end
                RD: state <= store_q ? MERGE : CAP;
                CAP: begin
                    bus.Resp_rdata <= format_load(f3_q, lane_q, bus.Mem_Rd_data);
                    bus.Resp_err   <= 2'b00;
                    bus.Resp_valid <= 1'b1;
                    state          <= IDLE;
                end
                MERGE: begin
                    bus.Mem_Wr_data <= merge_store(f3_q[0], lane_q, bus.Mem_Rd_data, wdata_q);
                    bus.MemWrite    <= 1'b1;
                    state           <= WR;
                end
                WR: begin
                    bus.Resp_rdata <= '0;
                    bus.Resp_err   <= 2'b00;
                    bus.Resp_valid <= 1'b1;
                    state          <= IDLE;
                end
                RESP: begin
                    bus.Resp_rdata <= '0;
                    bus.Resp_err   <= err_q;
                    bus.Resp_valid <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory sharing Clk/Rst.
// Latencies are counted in rising edges, the accept edge being the first.
module tb_load_store_unit;
    logic Clk = 1'b0;
    logic Rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    load_store_unit_if #(.N_ADDR(8), .N_BIT(32)) bus ();

    load_store_unit #(.N_ADDR(8), .N_BIT(32)) dut (
        .Clk(Clk),
        .Rst(Rst),
        .bus(bus)
    );

    always #5 Clk = ~Clk;

    // Data memory: reset blocks both the write and the read of that edge.
    logic [31:0] mem [0:255] = '{default: 32'h0};
    always @(posedge Clk) begin
        if (Rst) begin
            if (bus.MemWrite) mem[bus.Mem_Addr] <= bus.Mem_Wr_data;
            if (bus.MemRead)  bus.Mem_Rd_data   <= mem[bus.Mem_Addr];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        bus.Req_valid  = 1'b1;
        bus.Req_store  = st;
        bus.Req_funct3 = f3;
        bus.Req_addr   = a;
        bus.Req_wdata  = wd;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"},   32'(bus.Req_ready),   32'd1);
        check({tag, "_rvalid"},  32'(bus.Resp_valid),  32'd0);
        check({tag, "_rdata"},   bus.Resp_rdata,       32'd0);
        check({tag, "_err"},     32'(bus.Resp_err),    32'd0);
        check({tag, "_maddr"},   32'(bus.Mem_Addr),    32'd0);
        check({tag, "_mwdata"},  bus.Mem_Wr_data,      32'd0);
        check({tag, "_memwr"},   32'(bus.MemWrite),    32'd0);
        check({tag, "_memrd"},   32'(bus.MemRead),     32'd0);
    endtask

    // Presents one request, waits for acceptance and response, and checks everything seen.
    task automatic do_req(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic [1:0] exp_err,
                          input int exp_lat, input int exp_rds, input int exp_wrs,
                          input logic [31:0] exp_wr);
        int k, rds, wrs, lat;
        logic got, both;
        logic [31:0] wr_seen, addr_seen;
        drive(st, f3, a, wd);
        k = 0;
        while (!bus.Req_ready && k < 20) begin
            @(posedge Clk); #1; k++;
        end
        check({tag, "_ready"}, 32'(bus.Req_ready), 32'd1);
        @(posedge Clk); #1;
        bus.Req_valid = 1'b0;
        rds = 0; wrs = 0; lat = 0; got = 1'b0; both = 1'b0;
        wr_seen = 32'h0; addr_seen = 32'h0;
        for (int i = 1; i <= 10 && !got; i++) begin
            if (bus.MemRead) begin
                rds++;
                addr_seen = 32'(bus.Mem_Addr);
            end
            if (bus.MemWrite) begin
                wrs++;
                wr_seen   = bus.Mem_Wr_data;
                addr_seen = 32'(bus.Mem_Addr);
            end
            if (bus.MemRead && bus.MemWrite) both = 1'b1;
            if (bus.Resp_valid) begin
                got = 1'b1;
                lat = i;
            end else begin
                @(posedge Clk); #1;
            end
        end
        check({tag, "_resp"},   32'(got),            32'd1);
        check({tag, "_lat"},    32'(lat),            32'(exp_lat));
        check({tag, "_rdata"},  bus.Resp_rdata,      exp_rd);
        check({tag, "_err"},    32'(bus.Resp_err),   32'(exp_err));
        check({tag, "_nread"},  32'(rds),            32'(exp_rds));
        check({tag, "_nwrite"}, 32'(wrs),            32'(exp_wrs));
        check({tag, "_rdwr"},   32'(both),           32'd0);
        if (exp_wrs > 0) check({tag, "_wrdata"}, wr_seen, exp_wr);
        if (exp_rds + exp_wrs > 0) check({tag, "_maddr"}, addr_seen, {24'h0, a[9:2]});
    endtask

    initial begin
        int k;
        logic rdy_early, got;
        bus.Req_valid   = 1'b0;
        bus.Req_store   = 1'b0;
        bus.Req_funct3  = 3'b000;
        bus.Req_addr    = 32'h0;
        bus.Req_wdata   = 32'h0;

        // Reset state
        Rst = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check_idle("reset");
        Rst = 1'b1;

        // Word store, then every load flavour on the same word
        do_req("sw10",   1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        2'b00, 2, 0, 1, 32'hDEADBEEF);
        do_req("lb13",   1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFFDE, 2'b00, 3, 1, 0, 32'h0);
        do_req("lbu13",  1'b0, 3'b100, 32'h13, 32'h0,        32'h000000DE, 2'b00, 3, 1, 0, 32'h0);
        do_req("lh12",   1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFFDEAD, 2'b00, 3, 1, 0, 32'h0);
        do_req("lhu10",  1'b0, 3'b101, 32'h10, 32'h0,        32'h0000BEEF, 2'b00, 3, 1, 0, 32'h0);
        do_req("lw10",   1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 2'b00, 3, 1, 0, 32'h0);
        do_req("lb11",   1'b0, 3'b000, 32'h11, 32'h0,        32'hFFFFFFBE, 2'b00, 3, 1, 0, 32'h0);

        // Read-modify-write stores
        do_req("sb11",   1'b1, 3'b000, 32'h11, 32'h00000055, 32'h0,        2'b00, 4, 1, 1, 32'hDEAD55EF);
        do_req("lw10b",  1'b0, 3'b010, 32'h10, 32'h0,        32'hDEAD55EF, 2'b00, 3, 1, 0, 32'h0);
        do_req("sh16",   1'b1, 3'b001, 32'h16, 32'hFFFF1234, 32'h0,        2'b00, 4, 1, 1, 32'h12340000);
        do_req("lh16",   1'b0, 3'b001, 32'h16, 32'h0,        32'h00001234, 2'b00, 3, 1, 0, 32'h0);

        // Error responses: no memory traffic
        do_req("lw12",   1'b0, 3'b010, 32'h12,  32'h0, 32'h0, 2'b01, 2, 0, 0, 32'h0);
        do_req("sh400",  1'b1, 3'b001, 32'h400, 32'h0, 32'h0, 2'b10, 2, 0, 0, 32'h0);
        do_req("st100",  1'b1, 3'b100, 32'h0,   32'h0, 32'h0, 2'b11, 2, 0, 0, 32'h0);
        do_req("lw401",  1'b0, 3'b010, 32'h401, 32'h0, 32'h0, 2'b10, 2, 0, 0, 32'h0);
        do_req("ld011",  1'b0, 3'b011, 32'h10,  32'h0, 32'h0, 2'b11, 2, 0, 0, 32'h0);

        // Busy SH with a second request held on Req_valid
        drive(1'b1, 3'b001, 32'h20, 32'h0000ABCD);
        check("b2b_ready0", 32'(bus.Req_ready), 32'd1);
        @(posedge Clk); #1;
        drive(1'b0, 3'b010, 32'h20, 32'h0);
        rdy_early = 1'b0;
        got = 1'b0;
        k = 1;
        while (!bus.Resp_valid && k < 10) begin
            if (bus.Req_ready) rdy_early = 1'b1;
            @(posedge Clk); #1; k++;
        end
        check("b2b_sh_lat",   32'(k),                32'd4);
        check("b2b_busy",     32'(rdy_early),        32'd0);
        check("b2b_rdy_resp", 32'(bus.Req_ready),    32'd1);
        @(posedge Clk); #1;
        bus.Req_valid = 1'b0;
        k = 1;
        while (!bus.Resp_valid && k < 10) begin
            @(posedge Clk); #1; k++;
        end
        check("b2b_lw_lat",   32'(k),              32'd3);
        check("b2b_lw_rdata", bus.Resp_rdata,      32'h0000ABCD);

        // Reset while the RMW sits in WR: the write must never land
        drive(1'b1, 3'b000, 32'h20, 32'h00000077);
        @(posedge Clk); #1;
        bus.Req_valid = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_wr_memwr",  32'(bus.MemWrite),  32'd1);
        check("rst_wr_wdata",  bus.Mem_Wr_data,    32'h0000AB77);
        Rst = 1'b0;
        @(posedge Clk); #1;
        Rst = 1'b1;
        check_idle("rst_wr");
        @(posedge Clk); #1;
        check("rst_wr_novld", 32'(bus.Resp_valid), 32'd0);
        do_req("lw20",   1'b0, 3'b010, 32'h20, 32'h0, 32'h0000ABCD, 2'b00, 3, 1, 0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
